// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: packer FSM states,
// default element/lane sizing and an index-width helper.
package mm_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MM_BW = 8;
  localparam int MM_K  = 4;

  // Bits needed to index n items; never less than 1 so a single-item count still has a port.
  function automatic int mm_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_row_packer_if.sv
// Upstream FIFO pop port plus downstream row handshake for fifo_row_packer.
interface fifo_row_packer_if
  import mm_pkg::*;
#(
  parameter int BW   = MM_BW,
  parameter int K    = MM_K,
  parameter int ROWS = 4
) ();

  localparam int IW = mm_clog2(ROWS);

  logic              o_rd;
  logic              i_empty;
  logic [BW-1:0]     i_data;
  logic              o_valid;
  logic              i_ready;
  logic [K*BW-1:0]   o_row;
  logic [IW-1:0]     o_row_idx;
  logic              o_last;

  modport master (
    output o_rd,
    input  i_empty,
    input  i_data,
    output o_valid,
    input  i_ready,
    output o_row,
    output o_row_idx,
    output o_last
  );

  modport slave (
    input  o_rd,
    output i_empty,
    output i_data,
    input  o_valid,
    output i_ready,
    input  o_row,
    input  o_row_idx,
    input  o_last
  );

endinterface

// File: rtl/fifo_row_packer.sv
// Pops K scalar elements from a FWFT FIFO into one row vector and offers it
// downstream on valid/ready, tagged with a wrapping row index and last-row flag.
module fifo_row_packer
  import mm_pkg::*;
#(
  parameter int BW   = MM_BW,
  parameter int K    = MM_K,
  parameter int ROWS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  output logic        o_busy,
  fifo_row_packer_if.master bus
);

  localparam int LW = mm_clog2(K);
  localparam int IW = mm_clog2(ROWS);
  localparam logic [LW-1:0] LANE_LAST = LW'(K - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(ROWS - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [LW-1:0]   r_lane_cnt;
  logic [IW-1:0]   r_row_idx;
  logic [BW-1:0]   r_lane [K];
  logic            w_pop;
  logic            w_row_done;
  logic            w_accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= FILL;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = FILL;
    end else begin
      unique case (r_state)
        FILL: if (w_row_done)  w_state_next = HOLD;
        HOLD: if (bus.i_ready) w_state_next = FILL;
        default: w_state_next = FILL;
      endcase
    end
  end

  // Pop is gated by reset/flush as well as empty so no element is lost in an abort cycle.
  always_comb begin
    w_pop       = (r_state == FILL) && !bus.i_empty && !i_flush && !i_reset;
    w_row_done  = w_pop && (r_lane_cnt == LANE_LAST);
    w_accept    = (r_state == HOLD) && bus.i_ready;
    bus.o_rd    = w_pop;
    bus.o_valid = (r_state == HOLD);
    bus.o_last  = (r_state == HOLD) && (r_row_idx == IDX_LAST);
    o_busy      = (r_state != FILL) || (r_lane_cnt != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_lane_cnt <= '0;
      r_row_idx  <= '0;
    end else begin
      if (w_pop) r_lane_cnt <= w_row_done ? '0 : r_lane_cnt + 1'b1;
      if (w_accept) r_row_idx <= (r_row_idx == IDX_LAST) ? '0 : r_row_idx + 1'b1;
    end
  end

  assign bus.o_row_idx = r_row_idx;

  // Unwritten lanes keep the previous row's values; only a flush-free pop writes a lane.
  for (genvar j = 0; j < K; j++) begin : g_lane
    always_ff @(posedge i_clk) begin
      if (i_reset)                                r_lane[j] <= '0;
      else if (w_pop && (r_lane_cnt == LW'(j)))   r_lane[j] <= bus.i_data;
    end
    assign bus.o_row[j*BW +: BW] = r_lane[j];
  end

endmodule

// File: tb/tb_fifo_row_packer.sv
// Randomized and directed bench for fifo_row_packer with a behavioural FWFT
// FIFO upstream and a queue-based row scoreboard.
module tb_fifo_row_packer;

  localparam int BW   = 8;
  localparam int K    = 4;
  localparam int ROWS = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic busy;

  fifo_row_packer_if #(.BW(BW), .K(K), .ROWS(ROWS)) bus ();

  fifo_row_packer #(.BW(BW), .K(K), .ROWS(ROWS)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (flush),
    .o_busy  (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FWFT FIFO model (depth 16, async read, never pops on empty).
  logic [BW-1:0] fmem [DEPTH];
  int unsigned   wptr = 0;
  int unsigned   rptr = 0;
  logic          push_req = 1'b0;
  logic [BW-1:0] push_dat = '0;

  assign bus.i_empty = (wptr == rptr);
  assign bus.i_data  = fmem[rptr % DEPTH];

  always @(posedge clk) begin
    if (push_req && (wptr - rptr) < DEPTH) begin
      fmem[wptr % DEPTH] <= push_dat;
      wptr <= wptr + 1;
    end
    if (bus.o_rd && wptr != rptr) rptr <= rptr + 1;
  end

  // Scoreboard: bytes in push order not yet delivered or discarded.
  logic [BW-1:0] exp_q [$];
  int            pend = 0;
  int            idx_m = 0;
  int            rows_done = 0;
  bit            expect_valid = 0;
  bit            prev_valid = 0;
  bit            prev_hs = 0;
  logic [K*BW-1:0] prev_row = '0;
  bit            period_mode = 0;
  longint        cyc = 0;
  longint        last_hs = -1;

  always @(negedge clk) begin
    logic [K*BW-1:0] er;
    cyc++;
    check("busy", busy, pend != 0);
    if (bus.o_rd) check("rd_on_empty", bus.i_empty, 1'b0);
    if (reset || flush) begin
      check(reset ? "rd_in_reset" : "rd_in_flush", bus.o_rd, 1'b0);
      repeat (pend) if (exp_q.size() > 0) void'(exp_q.pop_front());
      pend = 0;
      idx_m = 0;
      expect_valid = 0;
      prev_valid = 0;
      prev_hs = 0;
    end else begin
      if (expect_valid) check("latency", bus.o_valid, 1'b1);
      expect_valid = 0;
      if (prev_valid && !prev_hs) begin
        check("hold_valid", bus.o_valid, 1'b1);
        check("hold_row", bus.o_row, prev_row);
      end
      if (bus.o_valid) begin
        check("rd_in_hold", bus.o_rd, 1'b0);
        check("last", bus.o_last, idx_m == ROWS - 1);
      end else begin
        check("last_idle", bus.o_last, 1'b0);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() < K) begin
          check("row_underflow", exp_q.size(), K);
        end else begin
          for (int j = 0; j < K; j++) er[j*BW +: BW] = exp_q[j];
          check("row", bus.o_row, er);
          check("row_idx", bus.o_row_idx, idx_m);
          repeat (K) void'(exp_q.pop_front());
        end
        pend -= K;
        idx_m = (idx_m + 1) % ROWS;
        rows_done++;
        if (period_mode && last_hs >= 0) check("period", cyc - last_hs, K + 1);
        last_hs = cyc;
      end
      if (bus.o_rd) begin
        pend++;
        if (pend == K) expect_valid = 1;
      end
      prev_valid = bus.o_valid;
      prev_row   = bus.o_row;
      prev_hs    = bus.o_valid && bus.i_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [BW-1:0] d);
    push_req = 1'b1;
    push_dat = d;
    exp_q.push_back(d);
    tick();
    push_req = 1'b0;
  endtask

  task automatic wait_rows(input int target, input int budget);
    int n;
    n = 0;
    while (rows_done < target && n < budget) begin
      tick();
      n++;
    end
    if (rows_done < target) check("timeout_rows", rows_done, target);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!bus.o_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", bus.o_valid, 1'b1);
  endtask

  initial begin
    int target;
    reset = 1'b1;
    flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_row", bus.o_row, '0);
    check("rst_idx", bus.o_row_idx, '0);
    check("rst_last", bus.o_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // 1: single row
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_byte(BW'(i));
    wait_rows(1, 20);
    check("t1_row_const", prev_row, 32'h04030201);

    // 2: four back-to-back rows, idx wraps, fixed period
    period_mode = 1;
    last_hs = -1;
    for (int i = 16; i < 32; i++) push_byte(BW'(i));
    wait_rows(5, 40);
    period_mode = 0;

    // 3: empty stall mid-row
    push_byte(8'hA0);
    push_byte(8'hA1);
    repeat (10) begin
      tick();
      check("t3_busy_stall", busy, 1'b1);
    end
    push_byte(8'hA2);
    push_byte(8'hA3);
    wait_rows(6, 20);

    // 4: backpressure with 4 more queued upstream
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(BW'($urandom));
    wait_valid(20);
    repeat (3) tick();
    repeat (8) begin
      tick();
      check("t4_fill", wptr - rptr, 4);
    end
    bus.i_ready = 1'b1;
    wait_rows(8, 30);

    // 5: flush after 3 lanes, with nonzero row index beforehand
    for (int i = 0; i < 4; i++) push_byte(BW'($urandom));
    wait_rows(9, 20);
    for (int i = 0; i < 3; i++) push_byte(BW'($urandom));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_idx", bus.o_row_idx, '0);
    for (int i = 0; i < 4; i++) push_byte(BW'(8'h55 + i));
    wait_rows(10, 20);
    check("t5_row_const", prev_row, 32'h58575655);

    // 5b: flush and ready together while holding
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(BW'($urandom));
    wait_valid(20);
    bus.i_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5b_valid", bus.o_valid, 1'b0);
    check("t5b_idx", bus.o_row_idx, '0);
    check("t5b_rows", rows_done, 10);

    // 6: reset while holding with ready high
    bus.i_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(BW'($urandom));
    wait_valid(20);
    tick();
    bus.i_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid", bus.o_valid, 1'b0);
    check("t6_row", bus.o_row, '0);
    check("t6_idx", bus.o_row_idx, '0);
    check("t6_fill", wptr - rptr, 4);
    check("t6_rows", rows_done, 10);
    wait_rows(11, 20);

    // Random soak: random push gaps and downstream backpressure
    for (int i = 0; i < 200; i++) begin
      bus.i_ready = 1'($urandom_range(0, 1));
      if ((wptr - rptr) < DEPTH - 1 && $urandom_range(0, 2) != 0) push_byte(BW'($urandom));
      else tick();
    end
    bus.i_ready = 1'b1;
    while ((exp_q.size() % K) != 0) push_byte(BW'($urandom));
    target = rows_done + exp_q.size() / K;
    wait_rows(target, 400);
    check("soak_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=done", rows_done);
    $fatal(1, "global timeout");
  end

endmodule
